// File: rtl/mem_wait_responder.sv
// mem_wait_responder
// Word-wide RAM responder for the multicycle controller's memory port.
// One request in flight: accept in IDLE, count LATENCY wait states, then
// present a held response until the requester takes it.  Misaligned or
// out-of-range addresses are reported through rsp_err and never touch RAM.
module mem_wait_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH);
  localparam logic [32:0] BYTE_LIMIT = 33'(DEPTH) << 2;
  localparam logic [3:0]  WAIT_INIT  = 4'(LATENCY);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [3:0]      cnt;
  logic            accept;
  logic            enter_resp;

  logic            wr_p0;
  logic            err_p0;
  logic [AW-1:0]   idx_p0;
  logic [31:0]     wdata_p0;

  logic [31:0]     mem [DEPTH];

  // Address check: non-word-aligned, or beyond the last RAM byte (unsigned).
  function automatic logic addr_err(input logic [31:0] a);
    return (a[1:0] != 2'b00) || ({1'b0, a} >= BYTE_LIMIT);
  endfunction

  assign accept     = req_valid && (state == IDLE);
  assign enter_resp = (state == WAIT) && (cnt == 4'd0);

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = WAIT;
      end
      WAIT: begin
        if (cnt == 4'd0) state_next = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Control state: FSM register, wait counter and response registers.
  // The counter is loaded with LATENCY and WAIT always lasts LATENCY+1
  // cycles, so the response appears LATENCY+1 edges after accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      state <= state_next;
      if (accept)
        cnt <= WAIT_INIT;
      else if ((state == WAIT) && (cnt != 4'd0))
        cnt <= cnt - 4'd1;
      if (enter_resp) begin
        rsp_err   <= err_p0;
        rsp_rdata <= (!wr_p0 && !err_p0) ? mem[idx_p0] : '0;
      end
    end
  end

  // ---- p0: request capture at accept; later request changes are ignored ----
  // Latched request copy, with the address check evaluated once at accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_p0    <= req_write;
      err_p0   <= addr_err(req_addr);
      idx_p0   <= req_addr[AW+1:2];
      wdata_p0 <= req_wdata;
    end
  end

  // ---- RAM commit on the edge entering RESP; reset aborts an uncommitted write ----
  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (!reset && enter_resp && wr_p0 && !err_p0)
      mem[idx_p0] <= wdata_p0;
  end

endmodule

// File: tb/tb_mem_wait_responder.sv
// Testbench for mem_wait_responder: directed scenarios plus randomized
// traffic checked against an associative-array RAM model.
module tb_mem_wait_responder;

  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;
  localparam int TMO     = 60;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_write, req_ready, rsp_valid, rsp_ready, rsp_err;
  logic [31:0] req_addr, req_wdata, rsp_rdata;

  logic        req_valid0, req_write0, req_ready0, rsp_valid0, rsp_ready0, rsp_err0;
  logic [31:0] req_addr0, req_wdata0, rsp_rdata0;

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] model_mem [int];

  always #5 clk = ~clk;

  mem_wait_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) u_dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  mem_wait_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid0), .req_write(req_write0), .req_addr(req_addr0),
    .req_wdata(req_wdata0), .req_ready(req_ready0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0),
    .rsp_rdata(rsp_rdata0), .rsp_err(rsp_err0)
  );

  // One full transaction on u_dut. Entered and left #1 after a rising edge.
  // lat = edges after the accept edge until rsp_valid is seen.
  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input int hold, input bit rnd_rdy,
                     output logic [31:0] rdata, output logic err,
                     output int lat, output bit to);
    int w;
    to = 0; lat = 0; w = 0;
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    rsp_ready = 1'b0;
    while (!req_ready && w < TMO) begin
      @(posedge clk); #1; w++;
    end
    if (!req_ready) to = 1;
    @(posedge clk); #1;                 // accept edge
    req_valid = 1'b0;
    req_addr  = $urandom;               // latched copy must be used
    req_wdata = $urandom;
    req_write = $urandom_range(0, 1);
    while (!rsp_valid && lat < TMO) begin
      if (rnd_rdy) rsp_ready = $urandom_range(0, 1);
      @(posedge clk); #1; lat++;
    end
    if (!rsp_valid) to = 1;
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    ntests++;
    if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      nfail++;
      $display("FAIL reset_state: got ready=%b valid=%b err=%b rdata=%h, want 1 0 0 0",
               req_ready, rsp_valid, rsp_err, rsp_rdata);
    end
    ntests++;
    if ({req_ready0, rsp_valid0, rsp_err0, rsp_rdata0} !== {1'b1, 1'b0, 1'b0, 32'h0}) begin
      nfail++;
      $display("FAIL reset_state_lat0: got ready=%b valid=%b err=%b rdata=%h, want 1 0 0 0",
               req_ready0, rsp_valid0, rsp_err0, rsp_rdata0);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] rd; logic er; int lat; bit to;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 0, 0, rd, er, lat, to);
    model_mem[4] = 32'hDEADBEEF;
    ntests++;
    if (to || lat !== LATENCY + 1 || er !== 1'b0 || rd !== 32'h0) begin
      nfail++;
      $display("FAIL write_0x10: got to=%0d lat=%0d err=%b rdata=%h, want 0 %0d 0 0",
               to, lat, er, rd, LATENCY + 1);
    end
    txn(1'b0, 32'h10, 32'h0, 0, 0, rd, er, lat, to);
    ntests++;
    if (to || lat !== LATENCY + 1 || er !== 1'b0 || rd !== 32'hDEADBEEF) begin
      nfail++;
      $display("FAIL read_0x10: got to=%0d lat=%0d err=%b rdata=%h, want 0 %0d 0 deadbeef",
               to, lat, er, rd, LATENCY + 1);
    end
    // last valid word
    txn(1'b1, 32'h3FC, 32'hA5A5_0FF0, 0, 0, rd, er, lat, to);
    txn(1'b0, 32'h3FC, 32'h0, 0, 0, rd, er, lat, to);
    model_mem[255] = 32'hA5A5_0FF0;
    ntests++;
    if (to || er !== 1'b0 || rd !== 32'hA5A5_0FF0) begin
      nfail++;
      $display("FAIL read_last_word: got to=%0d err=%b rdata=%h, want 0 0 a5a50ff0", to, er, rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd; logic er; int lat; bit to;
    txn(1'b1, 32'h100, 32'h1234_5678, 0, 0, rd, er, lat, to);
    txn(1'b1, 32'h000, 32'hCAFE_0000, 0, 0, rd, er, lat, to);
    model_mem[64] = 32'h1234_5678;
    model_mem[0]  = 32'hCAFE_0000;
    txn(1'b0, 32'h13, 32'h0, 0, 0, rd, er, lat, to);
    ntests++;
    if (to || er !== 1'b1 || rd !== 32'h0) begin
      nfail++;
      $display("FAIL misaligned_read: got to=%0d err=%b rdata=%h, want 0 1 0", to, er, rd);
    end
    txn(1'b1, 32'h400, 32'hFFFF_FFFF, 0, 0, rd, er, lat, to);
    ntests++;
    if (to || er !== 1'b1 || rd !== 32'h0) begin
      nfail++;
      $display("FAIL range_write: got to=%0d err=%b rdata=%h, want 0 1 0", to, er, rd);
    end
    txn(1'b1, 32'h102, 32'hFFFF_FFFF, 0, 0, rd, er, lat, to);
    txn(1'b0, 32'hFFFF_FFFC, 32'h0, 0, 0, rd, er, lat, to);
    ntests++;
    if (to || er !== 1'b1 || rd !== 32'h0) begin
      nfail++;
      $display("FAIL range_read_top: got to=%0d err=%b rdata=%h, want 0 1 0", to, er, rd);
    end
    txn(1'b0, 32'h100, 32'h0, 0, 0, rd, er, lat, to);
    ntests++;
    if (to || er !== 1'b0 || rd !== 32'h1234_5678) begin
      nfail++;
      $display("FAIL word_0x100_kept: got to=%0d err=%b rdata=%h, want 0 0 12345678", to, er, rd);
    end
    txn(1'b0, 32'h000, 32'h0, 0, 0, rd, er, lat, to);
    ntests++;
    if (to || er !== 1'b0 || rd !== 32'hCAFE_0000) begin
      nfail++;
      $display("FAIL word_0_kept: got to=%0d err=%b rdata=%h, want 0 0 cafe0000", to, er, rd);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd; logic er; int lat; bit to; int bad;
    txn(1'b1, 32'h40, 32'h0BAD_F00D, 0, 0, rd, er, lat, to);
    model_mem[16] = 32'h0BAD_F00D;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < TMO) begin
      @(posedge clk); #1; lat++;
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'h1111_2222;
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_err !== 1'b0 ||
          rsp_rdata !== 32'h0BAD_F00D) bad++;
    end
    ntests++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL backpressure_hold: %0d unstable cycles (valid=%b ready=%b err=%b rdata=%h), want 0",
               bad, rsp_valid, req_ready, rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    ntests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      nfail++;
      $display("FAIL backpressure_release: got valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
    end
    txn(1'b0, 32'h40, 32'h0, 0, 0, rd, er, lat, to);
    ntests++;
    if (to || er !== 1'b0 || rd !== 32'h0BAD_F00D) begin
      nfail++;
      $display("FAIL backpressure_no_accept: got to=%0d err=%b rdata=%h, want 0 0 0badf00d", to, er, rd);
    end
  endtask

  task automatic test_latency0();
    int hs;
    req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 32'h8; req_wdata0 = 32'h7777_0001;
    rsp_ready0 = 1'b0;
    @(posedge clk); #1;                 // accept edge N
    req_valid0 = 1'b0;
    ntests++;
    if (rsp_valid0 !== 1'b0) begin
      nfail++;
      $display("FAIL lat0_after_N: got rsp_valid=%b, want 0", rsp_valid0);
    end
    @(posedge clk); #1;                 // edge N+1
    ntests++;
    if (rsp_valid0 !== 1'b1 || rsp_err0 !== 1'b0) begin
      nfail++;
      $display("FAIL lat0_after_N1: got rsp_valid=%b err=%b, want 1 0", rsp_valid0, rsp_err0);
    end
    // Back-to-back reads of the just-written word, response always accepted.
    req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 32'h8; rsp_ready0 = 1'b1;
    hs = 0;
    for (int i = 0; i < 30; i++) begin
      if (rsp_valid0 && rsp_ready0) hs++;
      @(posedge clk); #1;
    end
    ntests++;
    if (hs != 10 || rsp_rdata0 !== 32'h7777_0001) begin
      nfail++;
      $display("FAIL lat0_throughput: got %0d responses rdata=%h in 30 cycles, want 10 77770001",
               hs, rsp_rdata0);
    end
    req_valid0 = 1'b0; rsp_ready0 = 1'b0;
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic er; int lat; bit to;
    txn(1'b1, 32'h20, 32'h1, 0, 0, rd, er, lat, to);
    model_mem[8] = 32'h1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'hBAD0_BAD0;
    @(posedge clk); #1;                 // accepted, now waiting
    req_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ntests++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_in_wait_state: got valid=%b ready=%b, want 0 1", rsp_valid, req_ready);
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
    end
    txn(1'b0, 32'h20, 32'h0, 0, 0, rd, er, lat, to);
    ntests++;
    if (to || er !== 1'b0 || rd !== 32'h1) begin
      nfail++;
      $display("FAIL reset_in_wait_dropped: got to=%0d err=%b rdata=%h, want 0 0 1", to, er, rd);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, addr, wd, exp_rd; logic er, exp_er, wr; int lat; bit to;
    int sel, bad, first_bad;
    longint unsigned a64;
    bad = 0; first_bad = -1;
    for (int n = 0; n < 1000; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)      addr = 32'($urandom_range(0, 15)) * 4;
      else if (sel < 9) addr = 32'($urandom_range(0, 63)) | 32'($urandom_range(1, 3));
      else              addr = 32'($urandom_range(1024, 32'h7FFF_FFFF)) + 32'($urandom_range(0, 1)) * 32'h8000_0000;
      wr = $urandom_range(0, 1);
      wd = $urandom;
      a64 = longint'(addr);
      exp_er = (a64 % 4 != 0) || (a64 >= 4 * DEPTH);
      exp_rd = 32'h0;
      if (!wr && !exp_er && model_mem.exists(int'(a64 / 4))) exp_rd = model_mem[int'(a64 / 4)];
      txn(wr, addr, wd, $urandom_range(0, 3), 1, rd, er, lat, to);
      if (wr && !exp_er) model_mem[int'(a64 / 4)] = wd;
      if (to || er !== exp_er || lat !== LATENCY + 1 ||
          ((wr || exp_er || model_mem.exists(int'(a64 / 4))) && rd !== exp_rd)) begin
        bad++;
        if (first_bad < 0) begin
          first_bad = n;
          $display("FAIL random_txn %0d: addr=%h wr=%b got to=%0d lat=%0d err=%b rdata=%h, want err=%b rdata=%h",
                   n, addr, wr, to, lat, er, rd, exp_er, exp_rd);
        end
      end
    end
    ntests++;
    if (bad != 0) begin
      nfail++;
      $display("FAIL random_traffic: %0d of 1000 transactions wrong, want 0", bad);
    end
  endtask

  initial begin
    reset = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0; rsp_ready = 0;
    req_valid0 = 0; req_write0 = 0; req_addr0 = 0; req_wdata0 = 0; rsp_ready0 = 0;
    test_reset();
    test_write_read();
    test_errors();
    test_backpressure();
    test_latency0();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
